sig_probe: RTL and testbench



---
 rtl/sig_probe_if.sv | 33 +++
 rtl/sig_probe.sv | 138 +++++++++++++
 tb/tb_sig_probe.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sig_probe_if.sv
// sig_probe_if: probe inputs and statistics outputs of sig_probe.
// The master side drives the probe, and the slave side is the sig_probe block.
interface sig_probe_if #(
  parameter int CNT_W = 16,
  parameter int ANA_W = 16
);
  logic             i_clr;
  logic             i_dig;
  logic [ANA_W-1:0] i_ana;
  logic             i_ana_vld;
  logic             o_level;
  logic [CNT_W-1:0] o_rise_cnt;
  logic [CNT_W-1:0] o_fall_cnt;
  logic [CNT_W-1:0] o_hi_cyc;
  logic [CNT_W-1:0] o_last_pw;
  logic [ANA_W-1:0] o_ana_last;
  logic [ANA_W-1:0] o_ana_min;
  logic [ANA_W-1:0] o_ana_max;
  logic [ANA_W-1:0] o_ana_avg;
  logic             o_ana_avg_vld;

  modport master (
    output i_clr, i_dig, i_ana, i_ana_vld,
    input  o_level, o_rise_cnt, o_fall_cnt, o_hi_cyc, o_last_pw,
           o_ana_last, o_ana_min, o_ana_max, o_ana_avg, o_ana_avg_vld
  );

  modport slave (
    input  i_clr, i_dig, i_ana, i_ana_vld,
    output o_level, o_rise_cnt, o_fall_cnt, o_hi_cyc, o_last_pw,
           o_ana_last, o_ana_min, o_ana_max, o_ana_avg, o_ana_avg_vld
  );
endinterface

// File: rtl/sig_probe.sv
// sig_probe: debug probe for one digital net and one analog-code bus.
// The digital path provides edge counts, high time and the last pulse width.
// The analog path provides last/min/max and a block average of 2^AVG_LOG2 samples.
// The analog path is compiled in only when SIG_PROBE_ANA_EN is defined.
// Otherwise, the analog outputs are tied to their reset values.
module sig_probe #(
  parameter int CNT_W    = 16,
  parameter int ANA_W    = 16,
  parameter int AVG_LOG2 = 4
) (
  input  logic         i_clk,
  input  logic         i_rstz,
  sig_probe_if.slave   bus
);

  // ---------------- digital path ----------------
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [CNT_W-1:0] rise_cnt, fall_cnt, hi_cyc, last_pw, pw_run;

  // i_dig may be asynchronous: two-flop synchronizer plus one history flop.
  // Clear does not touch these, so the edge history survives i_clr.
  always_ff @(posedge i_clk or negedge i_rstz) begin
    if (!i_rstz) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.i_dig;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Edge, high-time and pulse-width statistics, all saturating at all-ones.
  always_ff @(posedge i_clk or negedge i_rstz) begin
    if (!i_rstz) begin
      rise_cnt <= '0;
      fall_cnt <= '0;
      hi_cyc   <= '0;
      last_pw  <= '0;
      pw_run   <= '0;
    end else if (bus.i_clr) begin
      rise_cnt <= '0;
      fall_cnt <= '0;
      hi_cyc   <= '0;
      last_pw  <= '0;
      pw_run   <= '0;
    end else begin
      if (rise && rise_cnt != '1) rise_cnt <= rise_cnt + CNT_W'(1);
      if (fall && fall_cnt != '1) fall_cnt <= fall_cnt + CNT_W'(1);
      if (s2 && hi_cyc != '1)     hi_cyc   <= hi_cyc + CNT_W'(1);
      if (fall) begin
        last_pw <= pw_run;
        pw_run  <= '0;
      end else if (s2 && pw_run != '1) begin
        pw_run  <= pw_run + CNT_W'(1);
      end
    end
  end

  assign bus.o_level    = s2;
  assign bus.o_rise_cnt = rise_cnt;
  assign bus.o_fall_cnt = fall_cnt;
  assign bus.o_hi_cyc   = hi_cyc;
  assign bus.o_last_pw  = last_pw;

  // ---------------- analog path ----------------
`ifdef SIG_PROBE_ANA_EN
  // The accumulator is wide enough for a full block of all-ones samples.
  localparam int ACC_W = ANA_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] BLK_LAST = (AVG_LOG2+1)'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [AVG_LOG2:0] smp_cnt;
  logic [ANA_W-1:0]  ana_last, ana_min, ana_max, ana_avg;
  logic              ana_avg_vld;

  assign acc_nxt = acc + ACC_W'(bus.i_ana);

  // Per-sample statistics, with a block average emitted on the last sample of each block.
  always_ff @(posedge i_clk or negedge i_rstz) begin
    if (!i_rstz) begin
      acc         <= '0;
      smp_cnt     <= '0;
      ana_last    <= '0;
      ana_min     <= '1;
      ana_max     <= '0;
      ana_avg     <= '0;
      ana_avg_vld <= 1'b0;
    end else if (bus.i_clr) begin
      acc         <= '0;
      smp_cnt     <= '0;
      ana_last    <= '0;
      ana_min     <= '1;
      ana_max     <= '0;
      ana_avg     <= '0;
      ana_avg_vld <= 1'b0;
    end else begin
      ana_avg_vld <= 1'b0;
      if (bus.i_ana_vld) begin
        ana_last <= bus.i_ana;
        if (bus.i_ana < ana_min) ana_min <= bus.i_ana;
        if (bus.i_ana > ana_max) ana_max <= bus.i_ana;
        if (smp_cnt == BLK_LAST) begin
          ana_avg     <= acc_nxt[ACC_W-1:AVG_LOG2];
          ana_avg_vld <= 1'b1;
          acc         <= '0;
          smp_cnt     <= '0;
        end else begin
          acc     <= acc_nxt;
          smp_cnt <= smp_cnt + (AVG_LOG2+1)'(1);
        end
      end
    end
  end

  assign bus.o_ana_last    = ana_last;
  assign bus.o_ana_min     = ana_min;
  assign bus.o_ana_max     = ana_max;
  assign bus.o_ana_avg     = ana_avg;
  assign bus.o_ana_avg_vld = ana_avg_vld;
`else
  // The analog inputs are intentionally ignored in this build.
  logic unused_ana;
  assign unused_ana = ^{bus.i_ana, bus.i_ana_vld};

  assign bus.o_ana_last    = '0;
  assign bus.o_ana_min     = '1;
  assign bus.o_ana_max     = '0;
  assign bus.o_ana_avg     = '0;
  assign bus.o_ana_avg_vld = 1'b0;
`endif

endmodule

// File: tb/tb_sig_probe.sv
// tb_sig_probe: scoreboard bench for sig_probe.
// At each rising edge, the model computes the expected output state and queues it.
// The monitor pops the queued state on the following falling edge and compares it with the DUT.
module tb_sig_probe;
  localparam int CNT_W = 16;
  localparam int ANA_W = 16;
  localparam int AVG_N = 16;
  localparam int SAT   = 65535;

  logic clk = 1'b0;
  logic rstz = 1'b0;
  always #5 clk = ~clk;

  sig_probe_if #(.CNT_W(CNT_W), .ANA_W(ANA_W)) bus ();

  sig_probe #(.CNT_W(CNT_W), .ANA_W(ANA_W), .AVG_LOG2(4)) dut (
    .i_clk  (clk),
    .i_rstz (rstz),
    .bus    (bus.slave)
  );

  typedef struct {
    int lvl, rise, fall, hi, lpw, alast, amin, amax, aavg, avld;
  } snap_t;

  snap_t exp_q[$];
  int    n_tot = 0;
  int    n_bad = 0;
  bit    chk_en = 1'b1;
  int    avg_pulses = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int x);
    return (x >= SAT) ? SAT : x + 1;
  endfunction

  // The synchronized level is the input waveform delayed by two sampling edges.
  // The statistics react to the synchronized level seen in the cycle before each edge.
  initial begin : model
    bit    h[$];
    int    rise, fall, hi, lpw, pw, alast, amin, amax, aavg, avld, cyc;
    int    blk[$];
    bit    cur, prev;
    longint sum;
    snap_t s;
    h = '{0, 0, 0};
    rise = 0; fall = 0; hi = 0; lpw = 0; pw = 0;
    alast = 0; amin = SAT; amax = 0; aavg = 0; avld = 0; cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rstz) begin
        h = '{0, 0, 0};
        rise = 0; fall = 0; hi = 0; lpw = 0; pw = 0;
        alast = 0; amin = SAT; amax = 0; aavg = 0; avld = 0;
        blk.delete();
      end else begin
        h.push_back(bus.i_dig);
        while (h.size() > 4) h.pop_front();
        cur  = h[1];
        prev = h[0];
        if (bus.i_clr) begin
          rise = 0; fall = 0; hi = 0; lpw = 0; pw = 0;
          alast = 0; amin = SAT; amax = 0; aavg = 0; avld = 0;
          blk.delete();
        end else begin
          if (cur && !prev) rise = sat_inc(rise);
          if (!cur && prev) begin
            fall = sat_inc(fall);
            lpw  = pw;
            pw   = 0;
          end else if (cur) pw = sat_inc(pw);
          if (cur) hi = sat_inc(hi);
`ifdef SIG_PROBE_ANA_EN
          avld = 0;
          if (bus.i_ana_vld) begin
            alast = int'(bus.i_ana);
            if (alast < amin) amin = alast;
            if (alast > amax) amax = alast;
            blk.push_back(alast);
            if (blk.size() == AVG_N) begin
              sum = 0;
              foreach (blk[i]) sum += blk[i];
              aavg = int'(sum / AVG_N);
              avld = 1;
              blk.delete();
            end
          end
`endif
        end
      end
      s.lvl = rstz ? int'(h[2]) : 0;
      s.rise = rise; s.fall = fall; s.hi = hi; s.lpw = lpw;
      s.alast = alast; s.amin = amin; s.amax = amax; s.aavg = aavg; s.avld = avld;
      if (chk_en || (cyc % 4096) == 0) exp_q.push_back(s);
    end
  end

  // Monitor: compare the DUT outputs against the state queued for the preceding edge.
  initial begin : monitor
    snap_t e;
    forever begin
      @(negedge clk);
      if (bus.o_ana_avg_vld === 1'b1) avg_pulses++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("level",    int'(bus.o_level),       e.lvl);
        chk("rise_cnt", int'(bus.o_rise_cnt),    e.rise);
        chk("fall_cnt", int'(bus.o_fall_cnt),    e.fall);
        chk("hi_cyc",   int'(bus.o_hi_cyc),      e.hi);
        chk("last_pw",  int'(bus.o_last_pw),     e.lpw);
        chk("ana_last", int'(bus.o_ana_last),    e.alast);
        chk("ana_min",  int'(bus.o_ana_min),     e.amin);
        chk("ana_max",  int'(bus.o_ana_max),     e.amax);
        chk("ana_avg",  int'(bus.o_ana_avg),     e.aavg);
        chk("avg_vld",  int'(bus.o_ana_avg_vld), e.avld);
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clr();
    bus.i_clr = 1'b1;
    cyc(1);
    bus.i_clr = 1'b0;
  endtask

  initial begin : stim
    int p0;
    bus.i_clr = 1'b0; bus.i_dig = 1'b0; bus.i_ana = '0; bus.i_ana_vld = 1'b0;
    rstz = 1'b0;
    cyc(3);
    chk("rst_rise", int'(bus.o_rise_cnt), 0);
    chk("rst_min",  int'(bus.o_ana_min), SAT);
    rstz = 1'b1;
    cyc(3);

    // Drive a 5-cycle pulse aligned to the clock. The level follows two edges after sampling.
    bus.i_dig = 1'b1;
    cyc(1);
    chk("lvl_edge1", int'(bus.o_level), 0);
    cyc(1);
    chk("lvl_edge2", int'(bus.o_level), 1);
    cyc(3);
    bus.i_dig = 1'b0;
    cyc(6);
    chk("pulse_rise", int'(bus.o_rise_cnt), 1);
    chk("pulse_fall", int'(bus.o_fall_cnt), 1);
    chk("pulse_pw",   int'(bus.o_last_pw), 5);
    chk("pulse_hi",   int'(bus.o_hi_cyc), 5);

    // Assert clear in the same cycle the rise is detected, so the edge is discarded.
    do_clr();
    cyc(2);
    bus.i_dig = 1'b1;
    cyc(2);
    bus.i_clr = 1'b1;
    cyc(1);
    bus.i_clr = 1'b0;
    chk("clr_rise", int'(bus.o_rise_cnt), 0);
    chk("clr_hi",   int'(bus.o_hi_cyc), 0);
    chk("clr_pw",   int'(bus.o_last_pw), 0);
    bus.i_dig = 1'b0;
    cyc(5);

    // Hold the net high long enough to saturate the high-time and pulse-width counters.
    do_clr();
    chk_en = 1'b0;
    bus.i_dig = 1'b1;
    cyc((1 << CNT_W) + 10);
    chk_en = 1'b1;
    bus.i_dig = 1'b0;
    cyc(5);
    chk("sat_hi",   int'(bus.o_hi_cyc), SAT);
    chk("sat_pw",   int'(bus.o_last_pw), SAT);
    chk("sat_rise", int'(bus.o_rise_cnt), 1);

    // Feed 16 samples, 100..115, with gaps between them.
    do_clr();
    p0 = avg_pulses;
    for (int v = 100; v < 116; v++) begin
      bus.i_ana = ANA_W'(v);
      bus.i_ana_vld = 1'b1;
      cyc(1);
      bus.i_ana_vld = 1'b0;
      bus.i_ana = ANA_W'($urandom);
      cyc($urandom_range(0, 3));
    end
    cyc(2);
`ifdef SIG_PROBE_ANA_EN
    chk("blk_min",    int'(bus.o_ana_min), 100);
    chk("blk_max",    int'(bus.o_ana_max), 115);
    chk("blk_last",   int'(bus.o_ana_last), 115);
    chk("blk_avg",    int'(bus.o_ana_avg), 107);
    chk("blk_pulses", avg_pulses - p0, 1);
`else
    chk("off_min",    int'(bus.o_ana_min), SAT);
    chk("off_max",    int'(bus.o_ana_max), 0);
    chk("off_avg",    int'(bus.o_ana_avg), 0);
    chk("off_pulses", avg_pulses - p0, 0);
`endif

    // Feed a full block of all-ones samples. The average must not overflow.
    do_clr();
    bus.i_ana = '1;
    bus.i_ana_vld = 1'b1;
    cyc(AVG_N);
    bus.i_ana_vld = 1'b0;
    cyc(2);
`ifdef SIG_PROBE_ANA_EN
    chk("ones_avg", int'(bus.o_ana_avg), SAT);
`else
    chk("off_ones_avg", int'(bus.o_ana_avg), 0);
`endif

    // Randomized mix of net toggles, samples and occasional clears.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) bus.i_dig = ~bus.i_dig;
      bus.i_ana_vld = 1'($urandom);
      bus.i_ana = ANA_W'($urandom);
      bus.i_clr = ($urandom_range(0, 59) == 0);
      cyc(1);
    end
    bus.i_clr = 1'b0;
    bus.i_ana_vld = 1'b0;
    bus.i_dig = 1'b0;
    cyc(5);

    // Assert reset asynchronously mid-cycle, with the net high. Release must count one rise.
    bus.i_dig = 1'b1;
    cyc(4);
    #1 rstz = 1'b0;
    #1;
    chk("async_rise",  int'(bus.o_rise_cnt), 0);
    chk("async_level", int'(bus.o_level), 0);
    chk("async_hi",    int'(bus.o_hi_cyc), 0);
    cyc(2);
    rstz = 1'b1;
    cyc(5);
    chk("rel_rise", int'(bus.o_rise_cnt), 1);
    chk("rel_fall", int'(bus.o_fall_cnt), 0);
    bus.i_dig = 1'b0;
    cyc(5);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
